// File: rtl/ram_pkg.sv
// ram_pkg: shared types and width helpers for byte_en_dual_port_ram.
package ram_pkg;

    typedef enum logic {CLEAR, READY} state_e;

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int nb_of(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    function automatic int aw_of(input int depth);
        return clogb2(depth - 1);
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: STAGES-deep delay line for a read {valid, payload}; payload holds while valid is low.
module ram_rd_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    if (STAGES == 0) begin : g_bypass
        assign valid_out = valid_in;
        assign data_out  = data_in;
    end else begin : g_stages
        logic [STAGES-1:0] valid_q, valid_d;
        logic [W-1:0]      data_q [STAGES];
        logic [W-1:0]      data_d [STAGES];

        always_comb begin
            valid_d   = (valid_q << 1) | STAGES'(valid_in);
            data_d[0] = valid_in ? data_in : data_q[0];
            for (int i = 1; i < STAGES; i++)
                data_d[i] = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                valid_q <= '0;
                data_q  <= '{default: '0};
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign valid_out = valid_q[STAGES-1];
        assign data_out  = data_q[STAGES-1];
    end

endmodule

// File: rtl/byte_en_dual_port_ram.sv
// byte_en_dual_port_ram: single-clock true dual-port RAM, byte enables, pipelined reads, zero-fill sweep.
// Define RAM_PARITY_EN for per-byte even parity and the a/b_perr_out ports.
module byte_en_dual_port_ram
    import ram_pkg::*;
#(
    parameter int    RAM_WIDTH    = 32,
    parameter int    BYTE_W       = 8,
    parameter int    RAM_DEPTH    = 1024,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = "",
    localparam int   NB           = nb_of(RAM_WIDTH, BYTE_W),
    localparam int   AW           = aw_of(RAM_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 a_valid_in,
    input  logic                 a_we_in,
    input  logic [NB-1:0]        a_be_in,
    input  logic [AW-1:0]        a_addr_in,
    input  logic [RAM_WIDTH-1:0] a_data_in,
    output logic [RAM_WIDTH-1:0] a_data_out,
    output logic                 a_valid_out,
    input  logic                 b_valid_in,
    input  logic                 b_we_in,
    input  logic [NB-1:0]        b_be_in,
    input  logic [AW-1:0]        b_addr_in,
    input  logic [RAM_WIDTH-1:0] b_data_in,
    output logic [RAM_WIDTH-1:0] b_data_out,
    output logic                 b_valid_out,
`ifdef RAM_PARITY_EN
    output logic                 a_perr_out,
    output logic                 b_perr_out,
`endif
    output logic                 ready_out
);

`ifdef RAM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int P = RAM_WIDTH + PW;
    localparam bit SWEEP = (INIT_FILE == "");

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
`ifdef RAM_PARITY_EN
    logic [NB-1:0]        par [RAM_DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [RAM_WIDTH-1:0] w);
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++)
            r[i] = ^w[i*BYTE_W +: BYTE_W];
        return r;
    endfunction
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic          ready_q, ready_d;
    logic          sweeping;

    logic [1:0]           req_v, req_we, rd, wr, in_rng;
    logic [NB-1:0]        be    [2];
    logic [AW-1:0]        addr  [2];
    logic [RAM_WIDTH-1:0] wdat  [2];
    logic [P-1:0]         rword [2];
    logic [1:0]           rv_q, rv_d, vout;
    logic [P-1:0]         rp_q [2];
    logic [P-1:0]         rp_d [2];
    logic [P-1:0]         pout [2];

    assign req_v  = {b_valid_in, a_valid_in};
    assign req_we = {b_we_in, a_we_in};
    assign be[0]   = a_be_in;
    assign be[1]   = b_be_in;
    assign addr[0] = a_addr_in;
    assign addr[1] = b_addr_in;
    assign wdat[0] = a_data_in;
    assign wdat[1] = b_data_in;

    // Edges seen while reset is held must not touch the array.
    assign sweeping = (state_q == CLEAR) && SWEEP && !rst_in;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready_d = ready_q;
        if (state_q == CLEAR) begin
            if (!SWEEP || sweep_q == AW'(RAM_DEPTH - 1)) begin
                state_d = READY;
                ready_d = 1'b1;
            end else begin
                sweep_d = sweep_q + AW'(1);
            end
        end
    end

    // Array reads happen before this edge's writes, giving read-first collisions.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = int'(addr[p]) < RAM_DEPTH;
            rd[p]     = req_v[p] & ready_q & ~req_we[p];
            wr[p]     = req_v[p] & ready_q & req_we[p] & in_rng[p];
            rword[p]  = '0;
            if (in_rng[p]) begin
                rword[p][RAM_WIDTH-1:0] = mem[addr[p]];
`ifdef RAM_PARITY_EN
                rword[p][P-1] = |(par[addr[p]] ^ byte_par(mem[addr[p]]));
`endif
            end
            rv_d[p] = rd[p];
            rp_d[p] = rd[p] ? rword[p] : rp_q[p];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= CLEAR;
            sweep_q <= '0;
            ready_q <= 1'b0;
            rv_q    <= '0;
            rp_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            rp_q    <= rp_d;
        end
    end

    // Port B is applied first so port A overrides it on shared bytes.
    always_ff @(posedge clk_in) begin
        if (sweeping) begin
            mem[sweep_q] <= '0;
`ifdef RAM_PARITY_EN
            par[sweep_q] <= '0;
`endif
        end
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < NB; i++) begin
                if (wr[p] && be[p][i]) begin
                    mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdat[p][i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
                    par[addr[p]][i] <= ^wdat[p][i*BYTE_W +: BYTE_W];
`endif
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        ram_rd_pipe #(
            .W      (P),
            .STAGES (READ_LATENCY - 1)
        ) u_pipe (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .valid_in  (rv_q[p]),
            .data_in   (rp_q[p]),
            .valid_out (vout[p]),
            .data_out  (pout[p])
        );
    end

    assign ready_out   = ready_q;
    assign a_valid_out = vout[0];
    assign b_valid_out = vout[1];
    assign a_data_out  = pout[0][RAM_WIDTH-1:0];
    assign b_data_out  = pout[1][RAM_WIDTH-1:0];
`ifdef RAM_PARITY_EN
    assign a_perr_out  = pout[0][P-1];
    assign b_perr_out  = pout[1][P-1];
`endif

endmodule

// File: tb/tb_byte_en_dual_port_ram.sv
// tb_byte_en_dual_port_ram: three DUTs (READ_LATENCY 1..3) driven in lockstep against a memory-array reference model.
module tb_byte_en_dual_port_ram;

    localparam int DEPTH = 1024;
    localparam int HMAX  = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        av_i, awe, bv_i, bwe;
    logic [3:0]  abe, bbe;
    logic [9:0]  aad, bad;
    logic [31:0] adi, bdi;
    logic [2:0]  rdy, avo, bvo;
    logic [31:0] ado [3];
    logic [31:0] bdo [3];
`ifdef RAM_PARITY_EN
    logic [2:0]  ape, bpe;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        byte_en_dual_port_ram #(.READ_LATENCY(g + 1)) u_dut (
            .clk_in      (clk),
            .rst_in      (rst),
            .a_valid_in  (av_i),
            .a_we_in     (awe),
            .a_be_in     (abe),
            .a_addr_in   (aad),
            .a_data_in   (adi),
            .a_data_out  (ado[g]),
            .a_valid_out (avo[g]),
            .b_valid_in  (bv_i),
            .b_we_in     (bwe),
            .b_be_in     (bbe),
            .b_addr_in   (bad),
            .b_data_in   (bdi),
            .b_data_out  (bdo[g]),
            .b_valid_out (bvo[g]),
`ifdef RAM_PARITY_EN
            .a_perr_out  (ape[g]),
            .b_perr_out  (bpe[g]),
`endif
            .ready_out   (rdy[g])
        );
    end

    // Reference model: plain memory image plus a per-cycle log of issued reads.
    logic [31:0] ref_mem [DEPTH];
    bit          bad_par [DEPTH];
    bit          hav [HMAX];
    bit          hbv [HMAX];
    bit          hap [HMAX];
    bit          hbp [HMAX];
    logic [31:0] had [HMAX];
    logic [31:0] hbd [HMAX];
    logic [31:0] last_a [3];
    logic [31:0] last_b [3];
    bit          last_ap [3];
    bit          last_bp [3];
    int          cyc, rst_cyc, since, tests, fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit va, input bit wa, input logic [3:0] ba, input logic [9:0] xa,
                        input logic [31:0] da, input bit vb, input bit wb, input logic [3:0] bb,
                        input logic [9:0] xb, input logic [31:0] db);
        bit rdy_m;
        av_i = va; awe = wa; abe = ba; aad = xa; adi = da;
        bv_i = vb; bwe = wb; bbe = bb; bad = xb; bdi = db;
        rdy_m = since >= DEPTH;
        hav[cyc] = 1'b0;
        hbv[cyc] = 1'b0;
        if (rdy_m) begin
            if (va && !wa) begin hav[cyc] = 1'b1; had[cyc] = ref_mem[xa]; hap[cyc] = bad_par[xa]; end
            if (vb && !wb) begin hbv[cyc] = 1'b1; hbd[cyc] = ref_mem[xb]; hbp[cyc] = bad_par[xb]; end
            for (int i = 0; i < 4; i++) begin
                if (vb && wb && bb[i]) ref_mem[xb][8*i +: 8] = db[8*i +: 8];
                if (va && wa && ba[i]) ref_mem[xa][8*i +: 8] = da[8*i +: 8];
            end
            if (vb && wb && bb[0]) bad_par[xb] = 1'b0;
            if (va && wa && ba[0]) bad_par[xa] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        since++;
        if (since == DEPTH)
            for (int k = 0; k < DEPTH; k++) begin ref_mem[k] = '0; bad_par[k] = 1'b0; end
        for (int d = 0; d < 3; d++) begin
            automatic int j  = cyc - (d + 1);
            automatic bit ea = (j >= rst_cyc) && hav[j];
            automatic bit eb = (j >= rst_cyc) && hbv[j];
            if (ea) begin last_a[d] = had[j]; last_ap[d] = hap[j]; end
            if (eb) begin last_b[d] = hbd[j]; last_bp[d] = hbp[j]; end
            chk($sformatf("ready L%0d c%0d", d + 1, cyc), rdy[d], since >= DEPTH);
            chk($sformatf("a_valid L%0d c%0d", d + 1, cyc), avo[d], ea);
            chk($sformatf("b_valid L%0d c%0d", d + 1, cyc), bvo[d], eb);
            chk($sformatf("a_data L%0d c%0d", d + 1, cyc), ado[d], last_a[d]);
            chk($sformatf("b_data L%0d c%0d", d + 1, cyc), bdo[d], last_b[d]);
`ifdef RAM_PARITY_EN
            chk($sformatf("a_perr L%0d c%0d", d + 1, cyc), ape[d], last_ap[d]);
            chk($sformatf("b_perr L%0d c%0d", d + 1, cyc), bpe[d], last_bp[d]);
`endif
        end
        av_i = 1'b0;
        bv_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_a(input logic [9:0] x, input logic [31:0] d, input logic [3:0] b);
        step(1, 1, b, x, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_a(input logic [9:0] x);
        step(1, 0, 0, x, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_b(input logic [9:0] x);
        step(0, 0, 0, 0, 0, 1, 0, 0, x, 0);
    endtask

    task automatic do_reset();
        av_i = 1'b0;
        bv_i = 1'b0;
        rst  = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst ready L%0d", d + 1), rdy[d], 1'b0);
            chk($sformatf("rst a_valid L%0d", d + 1), avo[d], 1'b0);
            chk($sformatf("rst b_valid L%0d", d + 1), bvo[d], 1'b0);
            chk($sformatf("rst a_data L%0d", d + 1), ado[d], 32'h0);
            chk($sformatf("rst b_data L%0d", d + 1), bdo[d], 32'h0);
            last_a[d] = '0; last_b[d] = '0; last_ap[d] = 1'b0; last_bp[d] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        since   = 0;
        rst_cyc = cyc;
    endtask

    initial begin
        logic [31:0] r;
        av_i = 0; awe = 0; abe = 0; aad = 0; adi = 0;
        bv_i = 0; bwe = 0; bbe = 0; bad = 0; bdi = 0;
        cyc = 0; rst_cyc = 0; since = 0; tests = 0; fails = 0;
        for (int k = 0; k < DEPTH; k++) begin ref_mem[k] = '0; bad_par[k] = 1'b0; end
        #3;
        do_reset();

        // Sweep length and first read
        idle(DEPTH - 1);
        chk("ready_low_1023", rdy, 3'b000);
        idle(1);
        chk("ready_high_1024", rdy, 3'b111);
        rd_a(10'd1023);
        idle(3);
        for (int d = 0; d < 3; d++) chk($sformatf("t1 addr1023 L%0d", d + 1), ado[d], 32'h0);

        // Byte-enable merge and exact latency
        wr_a(10'd5, 32'hDEADBEEF, 4'hF);
        wr_a(10'd5, 32'h00000011, 4'h1);
        rd_b(10'd5);
        chk("t2 valid_early L2", bvo[1], 1'b0);
        idle(1);
        chk("t2 valid_at_2 L2", bvo[1], 1'b1);
        chk("t2 data L2", bdo[1], 32'hDEADBE11);

        // Same-address dual write, A wins shared bytes
        step(1, 1, 4'h3, 10'd9, 32'h11111111, 1, 1, 4'hE, 10'd9, 32'h22222222);
        rd_a(10'd9);
        idle(3);
        for (int d = 0; d < 3; d++) chk($sformatf("t3 merge L%0d", d + 1), ado[d], 32'h22221111);

        // Read-first collision
        wr_a(10'd3, 32'hAAAA5555, 4'hF);
        step(1, 1, 4'hF, 10'd3, 32'h12345678, 1, 0, 4'h0, 10'd3, 32'h0);
        idle(3);
        for (int d = 0; d < 3; d++) chk($sformatf("t4 old L%0d", d + 1), bdo[d], 32'hAAAA5555);
        rd_b(10'd3);
        idle(3);
        for (int d = 0; d < 3; d++) chk($sformatf("t4 new L%0d", d + 1), bdo[d], 32'h12345678);

        // Back-to-back bursts on both ports
        for (int k = 0; k < 8; k += 2)
            step(1, 1, 4'hF, 10'(k), $urandom, 1, 1, 4'hF, 10'(k + 1), $urandom);
        for (int k = 0; k < 8; k++)
            step(1, 0, 0, 10'(k), 0, 1, 0, 0, 10'(7 - k), 0);
        idle(3);

        // Reset during a burst, then again mid-sweep
        for (int k = 0; k < 4; k++)
            step(1, 0, 0, 10'(k), 0, 1, 0, 0, 10'(k + 4), 0);
        do_reset();
        idle(600);
        do_reset();
        idle(DEPTH - 1);
        chk("resweep ready_low", rdy, 3'b000);
        idle(1);
        for (int k = 0; k < 8; k++)
            step(1, 0, 0, 10'(k), 0, 1, 0, 0, 10'(7 - k), 0);
        idle(3);
        for (int d = 0; d < 3; d++) chk($sformatf("resweep zero L%0d", d + 1), ado[d], 32'h0);

`ifdef RAM_PARITY_EN
        wr_a(10'd7, 32'hC0FFEE01, 4'hF);
        wr_a(10'd8, 32'h0BADF00D, 4'hF);
        g_dut[0].u_dut.mem[7][0] = ~g_dut[0].u_dut.mem[7][0];
        g_dut[1].u_dut.mem[7][0] = ~g_dut[1].u_dut.mem[7][0];
        g_dut[2].u_dut.mem[7][0] = ~g_dut[2].u_dut.mem[7][0];
        ref_mem[7][0] = ~ref_mem[7][0];
        bad_par[7]    = 1'b1;
        rd_a(10'd7);
        idle(3);
        chk("t6 perr addr7", ape, 3'b111);
        rd_a(10'd8);
        idle(3);
        chk("t6 perr addr8", ape, 3'b000);
`endif

        // Random traffic concentrated on a few addresses to force collisions
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            step(r[1:0] != 2'b00, r[2], 4'($urandom), (r[5:4] == 2'b00) ? 10'd1023 : 10'($urandom % 16),
                 $urandom,
                 r[7:6] != 2'b00, r[8], 4'($urandom), (r[11:10] == 2'b00) ? 10'd1023 : 10'($urandom % 16),
                 $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
